// File: rtl/divisor_sequencial.sv
// Restoring shift-subtract unsigned divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// Latency: Done pulses N+1 edges after the start edge, or 1 edge after it on overflow or divide-by-zero.
// Backpressure: none; St is only sampled in IDLE, and results are held until the next accepted start.
module divisor_sequencial #(
   parameter int N = 16
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic           St,
   input  logic [2*N-1:0] Dividendo,
   input  logic [N-1:0]   Divisor,
   output logic           Idle,
   output logic           Done,
   output logic           Overflow,
   output logic [N-1:0]   Quociente,
   output logic [N-1:0]   Resto
);

   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;

   state_t          state, next_state;
   logic [2*N:0]    acc;        // {carry, partial remainder, quotient bits}
   logic [N-1:0]    dvsr;
   logic [CW-1:0]   cnt;

   logic [N:0]      partial;
   logic [N:0]      diff;
   logic            fits;
   logic [2*N:0]    acc_step;
   logic            ovf_chk;
   logic            last_step;

   // One restoring step: shift left, trial-subtract, shift in the quotient bit
   always_comb begin
      partial   = acc[2*N-1:N-1];
      fits      = partial >= {1'b0, dvsr};
      diff      = partial - {1'b0, dvsr};
      acc_step  = {(fits ? diff : partial), acc[N-2:0], fits};
      // Upper half >= divisor means the quotient cannot fit N bits; also catches a zero divisor
      ovf_chk   = acc[2*N:N] >= {1'b0, dvsr};
      last_step = cnt == CW'(N - 1);
   end

   // State register
   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state and handshake outputs
   always_comb begin
      next_state = state;
      Idle       = 1'b0;
      Done       = 1'b0;
      case (state)
         IDLE: begin
            Idle = 1'b1;
            if (St) next_state = CHECK;
         end
         CHECK:   next_state = ovf_chk ? DONE : DIV;
         DIV:     if (last_step) next_state = DONE;
         DONE: begin
            Done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, and result registers loaded on entry to DONE
   always_ff @(posedge Clk) begin
      if (Reset) begin
         acc       <= '0;
         dvsr      <= '0;
         cnt       <= '0;
         Overflow  <= 1'b0;
         Quociente <= '0;
         Resto     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (St) begin
                  acc      <= {1'b0, Dividendo};
                  dvsr     <= Divisor;
                  Overflow <= 1'b0;
               end
            end
            CHECK: begin
               if (ovf_chk) begin
                  Overflow  <= 1'b1;
                  Quociente <= '1;
                  Resto     <= '0;
               end else begin
                  cnt <= '0;
               end
            end
            DIV: begin
               acc <= acc_step;
               cnt <= cnt + 1'b1;
               if (last_step) begin
                  Quociente <= acc_step[N-1:0];
                  Resto     <= acc_step[2*N-1:N];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_divisor_sequencial.sv
// Bench for divisor_sequencial: directed table, handshake corner sequences, random vs. arithmetic model.
// Checks results, latency, reset behaviour and Idle/Done exclusivity.
// Inputs driven on falling edges; outputs sampled 1 time unit after rising edges.
module tb_divisor_sequencial;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        St;
   logic [31:0] Dividendo;
   logic [15:0] Divisor;
   logic        Idle, Done, Overflow;
   logic [15:0] Quociente, Resto;

   int vectors = 0;
   int errors  = 0;

   divisor_sequencial #(.N(16)) dut (
      .Clk(Clk), .Reset(Reset), .St(St), .Dividendo(Dividendo), .Divisor(Divisor),
      .Idle(Idle), .Done(Done), .Overflow(Overflow), .Quociente(Quociente), .Resto(Resto)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [31:0] dd;
      logic [15:0] dv;
      logic [15:0] q;
      logic [15:0] r;
      logic        ovf;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer division with the quotient-width overflow rule
   task automatic model(input logic [31:0] dd, input logic [15:0] dv,
                        output logic [15:0] q, output logic [15:0] r, output logic ovf);
      if (dv == 16'd0 || dd / {16'd0, dv} > 32'd65535) begin
         q = 16'hFFFF; r = 16'd0; ovf = 1'b1;
      end else begin
         q = 16'(dd / {16'd0, dv}); r = 16'(dd % {16'd0, dv}); ovf = 1'b0;
      end
   endtask

   // Start one division once the DUT is idle; report results and edges from acceptance to Done
   task automatic run_op(input logic [31:0] dd, input logic [15:0] dv,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic ovf, output int lat);
      int k = 0;
      @(negedge Clk);
      while (!Idle && k < 40) begin @(negedge Clk); k++; end
      Dividendo = dd; Divisor = dv; St = 1'b1;
      @(posedge Clk); #1;
      St = 1'b0;
      Dividendo = $urandom;           // must be ignored after acceptance
      Divisor   = 16'($urandom);
      lat = 0;
      while (!Done && lat < 40) begin @(posedge Clk); lat++; #1; end
      q = Quociente; r = Resto; ovf = Overflow;
   endtask

   always @(negedge Clk) begin
      if (!Reset && Idle && Done) begin
         errors++;
         $display("FAIL idle_done_excl: Idle=%b Done=%b, required not both high", Idle, Done);
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL timeout: simulation still running, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        tbl[8];
      logic [15:0] q, r, eq, er;
      logic        ovf, eovf;
      int          lat, dcount, first_done, second_done;

      tbl[0] = '{32'd100,        16'd7,      16'd14,     16'd2, 1'b0, 17};
      tbl[1] = '{32'hFFFE0001,   16'hFFFF,   16'hFFFF,   16'd0, 1'b0, 17};
      tbl[2] = '{32'h0006FFFF,   16'd7,      16'hFFFF,   16'd6, 1'b0, 17};
      tbl[3] = '{32'h00070000,   16'd7,      16'hFFFF,   16'd0, 1'b1, 1};
      tbl[4] = '{32'd5,          16'd0,      16'hFFFF,   16'd0, 1'b1, 1};
      tbl[5] = '{32'd1000,       16'd10,     16'd100,    16'd0, 1'b0, 17};
      tbl[6] = '{32'd0,          16'd5,      16'd0,      16'd0, 1'b0, 17};
      tbl[7] = '{32'h00040000,   16'd5,      16'd52428,  16'd4, 1'b0, 17};

      Reset = 1'b1; St = 1'b0; Dividendo = '0; Divisor = '0;
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_idle", Idle, 1'b1);
      chk("rst_done", Done, 1'b0);
      chk("rst_ovf",  Overflow, 1'b0);
      chk("rst_q",    Quociente, 16'd0);
      chk("rst_r",    Resto, 16'd0);
      @(negedge Clk); Reset = 1'b0;

      // Directed table
      for (int i = 0; i < 8; i++) begin
         run_op(tbl[i].dd, tbl[i].dv, q, r, ovf, lat);
         chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
         chk($sformatf("tbl%0d_q", i),   q,   tbl[i].q);
         chk($sformatf("tbl%0d_r", i),   r,   tbl[i].r);
         chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].ovf);
         @(posedge Clk); #1;
         chk($sformatf("tbl%0d_idle_after", i), {Idle, Done}, 2'b10);
      end

      // St pulse and dividend change during DIV are ignored
      @(negedge Clk);
      Dividendo = 32'd100; Divisor = 16'd7; St = 1'b1;
      @(posedge Clk); #1; St = 1'b0;
      dcount = 0; first_done = -1;
      for (int e = 1; e <= 30; e++) begin
         if (e == 5) begin @(negedge Clk); Dividendo = 32'd50; St = 1'b1; end
         @(posedge Clk); #1;
         if (e == 5) St = 1'b0;
         if (Done) begin
            dcount++;
            if (first_done < 0) begin first_done = e; q = Quociente; r = Resto; end
         end
      end
      chk("mask_pulses", 64'(dcount), 64'd1);
      chk("mask_lat",    64'(first_done), 64'd17);
      chk("mask_q",      q, 16'd14);
      chk("mask_r",      r, 16'd2);

      // St held high: back-to-back operations with one IDLE cycle between
      @(negedge Clk);
      Dividendo = 32'd100; Divisor = 16'd7; St = 1'b1;
      @(posedge Clk); #1;
      first_done = -1; second_done = -1;
      for (int e = 1; e <= 36; e++) begin
         @(posedge Clk); #1;
         if (e == 18) chk("held_idle_gap", Idle, 1'b1);
         if (e == 19) chk("held_restart",  Idle, 1'b0);
         if (Done) begin
            if (first_done < 0) first_done = e;
            else                second_done = e;
         end
      end
      St = 1'b0;
      chk("held_first",  64'(first_done),  64'd17);
      chk("held_second", 64'(second_done), 64'd36);

      // Reset mid-operation
      run_op(32'd1000, 16'd9, q, r, ovf, lat);   // leaves non-zero results in the output registers
      @(negedge Clk);
      while (!Idle) @(negedge Clk);
      Dividendo = 32'd100; Divisor = 16'd7; St = 1'b1;
      @(posedge Clk); #1; St = 1'b0;
      repeat (7) @(posedge Clk);
      @(negedge Clk); Reset = 1'b1;
      @(posedge Clk); #1;
      chk("midrst_idle", Idle, 1'b1);
      chk("midrst_done", Done, 1'b0);
      chk("midrst_q",    Quociente, 16'd0);
      chk("midrst_r",    Resto, 16'd0);
      @(negedge Clk); Reset = 1'b0;
      dcount = 0;
      for (int e = 0; e < 20; e++) begin @(posedge Clk); #1; if (Done) dcount++; end
      chk("midrst_nodone", 64'(dcount), 64'd0);
      run_op(32'd1000, 16'd10, q, r, ovf, lat);
      chk("post_rst_q", q, 16'd100);
      chk("post_rst_r", r, 16'd0);

      // Random against the arithmetic model
      for (int i = 0; i < 1000; i++) begin
         logic [31:0] dd;
         logic [15:0] dv;
         dv = 16'($urandom_range(1, 65535));
         dd = $urandom;
         if (i % 2 == 0) dd[31:16] = 16'($urandom % {16'd0, dv});
         model(dd, dv, eq, er, eovf);
         run_op(dd, dv, q, r, ovf, lat);
         chk($sformatf("rnd%0d_ovf dd=%0h dv=%0h", i, dd, dv), ovf, eovf);
         chk($sformatf("rnd%0d_ovf_rule", i), ovf, dd[31:16] >= dv);
         chk($sformatf("rnd%0d_q", i), q, eq);
         chk($sformatf("rnd%0d_r", i), r, er);
         chk($sformatf("rnd%0d_lat", i), 64'(lat), eovf ? 64'd1 : 64'd17);
         if (!eovf) begin
            chk($sformatf("rnd%0d_inv", i), 32'(q) * 32'(dv) + 32'(r), dd);
            chk($sformatf("rnd%0d_rem_lt", i), r < dv, 1'b1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/divisor_sequencial.md
Name: divisor_sequencial

Overview:
- Sequential shift-subtract (restoring) unsigned divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and N-bit remainder.
- It is the inverse datapath of the team's shift-add multiplier and uses the same St/Idle/Done handshake, so the MIPS CPU control can run both the same way.
- It is used for DIV/DIVU-style operations.
- It detects overflow, including divide-by-zero, before iterating.

Parameters:
- N, 16, divisor/quotient/remainder width; dividend is 2N bits.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- St  input  1  start request; sampled only in IDLE
- Dividendo  input  2N  dividend; latched when St is accepted
- Divisor  input  N  divisor; latched when St is accepted
- Idle  output  1  high only in IDLE state
- Done  output  1  one-cycle pulse; result valid
- Overflow  output  1  quotient does not fit N bits (includes Divisor=0); valid with Done, held until next start
- Quociente  output  N  quotient
- Resto  output  N  remainder

Behaviour:
- Reset (synchronous, active-high) forces:
  - state IDLE, Idle=1, Done=0, Overflow=0
  - Quociente=0, Resto=0
  - internal dividend register, divisor register and counter cleared
- Reset mid-operation aborts with no Done pulse.
- Internal state:
  - 2N+1-bit accumulator ACC = {carry, upper N bits (partial remainder), lower N bits (quotient)}
  - N-bit divisor register
  - log2(N)+1-bit step counter
- States:
  - IDLE:
    - Idle=1.
    - On St=1: ACC={0,Dividendo}, latch Divisor, Overflow=0, go to CHECK.
    - Otherwise stay.
  - CHECK:
    - If ACC upper N bits >= divisor (covers Divisor=0): Overflow=1, Quociente=all ones, Resto=0, go to DONE.
    - Else: counter=0, go to DIV.
  - DIV: one quotient bit per cycle.
    - Shift ACC left 1, capturing the upper bit into carry, giving a 17-bit partial remainder for N=16.
    - If that 17-bit partial remainder >= {0,divisor}: subtract the divisor (17-bit subtract) and set ACC[0]=1; else ACC[0]=0.
    - Shift and conditional subtract occur in the same cycle.
    - Increment counter; after the N-th step go to DONE.
  - DONE:
    - Done=1 for exactly one cycle.
    - Quociente=ACC lower N bits, Resto=ACC upper N bits, both registered.
    - Go to IDLE unconditionally.
- Latency, counting the edge that accepts St as edge 0:
  - Normal: Done high in the cycle after edge N+1 (edge 17 for N=16).
  - Overflow: Done high in the cycle after edge 1.
- Outputs:
  - Quociente, Resto and Overflow hold their values through DONE and IDLE until the next accepted St.
  - They do not change during CHECK/DIV; only internal ACC updates.
- Handshake:
  - St is ignored in CHECK, DIV and DONE.
  - St held high continuously starts a new operation on the first IDLE cycle after DONE, so there is one idle cycle between operations.
  - Dividendo and Divisor changes after acceptance are ignored.
- Arithmetic: unsigned only; signed handling is done by the caller.
- Invariants:
  - Every non-overflow result satisfies Quociente*Divisor + Resto = Dividendo and Resto < Divisor.
  - Idle and Done are never high together.

Test Plan:
- Basic: Reset 2 cycles, then Dividendo=100, Divisor=7, St pulse -> Done pulse 17 edges after acceptance; Quociente=14, Resto=2, Overflow=0; Idle=1 next cycle.
- Max range: Dividendo=32'hFFFE0001, Divisor=16'hFFFF -> Quociente=16'hFFFF, Resto=0, Overflow=0. Also Dividendo=32'h0006FFFF, Divisor=7 -> Quociente=16'hFFFF, Resto=6.
- Overflow and divide-by-zero:
  - Dividendo=32'h00070000, Divisor=7 -> Done after 1 edge, Overflow=1, Quociente=16'hFFFF, Resto=0.
  - Dividendo=5, Divisor=0 -> same response.
- Input stability and St masking: start 100/7; change Dividendo to 50 and pulse St at edge 5 -> result still 14/2, only one Done pulse. With St held high, a second operation starts exactly one IDLE cycle after DONE.
- Reset mid-operation: start 100/7, assert Reset at edge 8 -> next cycle Idle=1, Done=0, Quociente=0, Resto=0, no Done pulse. Then start 1000/10 -> Quociente=100, Resto=0.
- Random: 1000 random unsigned pairs with Divisor != 0 -> check the invariants or Overflow=1 exactly when Dividendo[31:16] >= Divisor; check Idle/Done mutual exclusion every cycle.
